// File: rtl/psk_pkg.sv
// Shared widths and constants for the BPSK modulator and its sine ROM.
package psk_pkg;

    localparam int unsigned PHASE_W = 16;
    localparam int unsigned LUT_AW  = 8;
    localparam int unsigned DAC_W   = 8;

    localparam logic [DAC_W-1:0]  DAC_MID    = 8'd128;
    localparam logic [LUT_AW-1:0] PSK_OFFSET = 8'd128;

    typedef logic [LUT_AW-1:0] lut_addr_t;
    typedef logic [DAC_W-1:0]  dac_sample_t;

endpackage

// File: rtl/sine_rom.sv
// 256 x 8 offset-binary sine ROM, folded onto a 65-entry quarter-wave table.
module sine_rom
    import psk_pkg::*;
(
    input  lut_addr_t   addr,
    output dac_sample_t sample_c
);

    localparam int unsigned QTR_N = 65;

    // round(127.5 + 127.5*sin(2*pi*k/256)) for k = 0..64
    localparam logic [DAC_W-1:0] QUARTER [QTR_N] = '{
        8'd128, 8'd131, 8'd134, 8'd137, 8'd140, 8'd143, 8'd146, 8'd149,
        8'd152, 8'd155, 8'd158, 8'd162, 8'd165, 8'd167, 8'd170, 8'd173,
        8'd176, 8'd179, 8'd182, 8'd185, 8'd188, 8'd190, 8'd193, 8'd196,
        8'd198, 8'd201, 8'd203, 8'd206, 8'd208, 8'd211, 8'd213, 8'd215,
        8'd218, 8'd220, 8'd222, 8'd224, 8'd226, 8'd228, 8'd230, 8'd232,
        8'd234, 8'd235, 8'd237, 8'd238, 8'd240, 8'd241, 8'd243, 8'd244,
        8'd245, 8'd246, 8'd248, 8'd249, 8'd250, 8'd250, 8'd251, 8'd252,
        8'd253, 8'd253, 8'd254, 8'd254, 8'd254, 8'd255, 8'd255, 8'd255,
        8'd255
    };

    logic [1:0]        quad;
    logic [5:0]        off;
    logic [6:0]        idx;
    logic [DAC_W-1:0]  q_val;

    // Odd quadrants mirror the index; the lower half-wave is 255 - upper,
    // except entry 128 which rounds to mid-scale rather than 127.
    always_comb begin
        quad     = addr[LUT_AW-1:LUT_AW-2];
        off      = addr[LUT_AW-3:0];
        idx      = quad[0] ? 7'(7'd64 - 7'(off)) : 7'(off);
        q_val    = QUARTER[idx];
        sample_c = q_val;
        if (quad[1]) begin
            if (!quad[0] && off == 6'd0) begin
                sample_c = DAC_MID;
            end else begin
                sample_c = 8'(8'd255 - q_val);
            end
        end
    end

endmodule

// File: rtl/psk_modulator.sv
// BPSK modulator: DDS sine carrier whose phase is flipped 180 degrees by data_in.
module psk_modulator
    import psk_pkg::*;
#(
    parameter logic [PHASE_W-1:0] BASE_PHASE = 16'd655
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    input  logic             data_in,
    output logic [DAC_W-1:0] da_data,
    output logic             da_clk
);

    logic [PHASE_W-1:0] phase_acc;
    logic               data_q;
    lut_addr_t          addr_c;
    dac_sample_t        lut_c;

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            phase_acc <= '0;
            data_q    <= 1'b0;
            da_data   <= DAC_MID;
        end else begin
            phase_acc <= phase_acc + BASE_PHASE;
            data_q    <= data_in;
            da_data   <= lut_c;
        end
    end

    // A set data bit adds half a table period, i.e. a 180 degree phase shift.
    always_comb begin
        addr_c = phase_acc[PHASE_W-1 -: LUT_AW] + (data_q ? PSK_OFFSET : lut_addr_t'(0));
    end

    sine_rom u_sine_rom (
        .addr     (addr_c),
        .sample_c (lut_c)
    );

    // DAC latches mid-period, half a cycle after da_data updates.
    assign da_clk = ~sys_clk;

endmodule

// File: tb/tb_psk_modulator.sv
// Self-checking bench for psk_modulator against a real-arithmetic sine/phase model.
module tb_psk_modulator;

    localparam int  BASE = 655;
    localparam real PI   = 3.14159265358979323846;

    logic       sys_clk = 1'b0;
    logic       sys_rst = 1'b1;
    logic       data_in = 1'b0;
    logic [7:0] da_data;
    logic       da_clk;

    int errors = 0;
    int checks = 0;
    int lut [256];
    int m_acc = 0;
    int m_dq  = 0;
    int cyc   = 0;

    psk_modulator #(.BASE_PHASE(16'(BASE))) dut (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .data_in (data_in),
        .da_data (da_data),
        .da_clk  (da_clk)
    );

    always #10 sys_clk = ~sys_clk;

    function automatic int ref_sample(input int k);
        real v;
        v = $floor(127.5 + 127.5 * $sin(2.0 * PI * real'(k) / 256.0) + 0.5);
        if (v < 0.0)   v = 0.0;
        if (v > 255.0) v = 255.0;
        return $rtoi(v);
    endfunction

    // Drive one cycle, advance the model across the edge, return expected da_data.
    task automatic step(input logic rst, input logic d, output int expv);
        sys_rst = rst;
        data_in = d;
        @(posedge sys_clk);
        if (rst) begin
            expv  = 128;
            m_acc = 0;
            m_dq  = 0;
        end else begin
            expv  = lut[((m_acc / 256) + 128 * m_dq) % 256];
            m_acc = (m_acc + BASE) % 65536;
            m_dq  = d ? 1 : 0;
        end
        cyc++;
        #1;
    endtask

    task automatic test_reset();
        int e;
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 1'b0, e);
            checks++;
            if (da_data !== 8'(e)) begin
                errors++;
                $display("FAIL reset_data: da_data=%0d expected %0d (cycle %0d)", da_data, e, cyc);
            end
            checks++;
            if (da_clk !== 1'b0) begin
                errors++;
                $display("FAIL reset_da_clk_high: da_clk=%b expected 0 (cycle %0d)", da_clk, cyc);
            end
            @(negedge sys_clk);
            #1;
            checks++;
            if (da_clk !== 1'b1) begin
                errors++;
                $display("FAIL reset_da_clk_low: da_clk=%b expected 1 (cycle %0d)", da_clk, cyc);
            end
        end
    endtask

    task automatic test_release();
        int e;
        int fixed;
        for (int i = 0; i < 30; i++) begin
            step(1'b0, 1'b0, e);
            checks++;
            if (da_data !== 8'(e)) begin
                errors++;
                $display("FAIL release_model: da_data=%0d expected %0d (edge %0d)", da_data, e, i + 1);
            end
            fixed = -1;
            if (i == 0)  fixed = 128;
            if (i == 1)  fixed = 134;
            if (i == 25) fixed = 255;
            if (fixed >= 0) begin
                checks++;
                if (da_data !== 8'(fixed)) begin
                    errors++;
                    $display("FAIL release_key: da_data=%0d expected %0d (edge %0d)", da_data, fixed, i + 1);
                end
            end
        end
    endtask

    task automatic test_phase_flip();
        int e;
        int fixed;
        step(1'b1, 1'b0, e);
        checks++;
        if (da_data !== 8'(e)) begin
            errors++;
            $display("FAIL flip_reset: da_data=%0d expected %0d", da_data, e);
        end
        // data_in rises for the 25th edge; inversion shows on the 26th.
        for (int i = 0; i < 26; i++) begin
            step(1'b0, (i >= 24) ? 1'b1 : 1'b0, e);
            checks++;
            if (da_data !== 8'(e)) begin
                errors++;
                $display("FAIL flip_model: da_data=%0d expected %0d (edge %0d)", da_data, e, i + 1);
            end
            fixed = -1;
            if (i == 24) fixed = 255;
            if (i == 25) fixed = 0;
            if (fixed >= 0) begin
                checks++;
                if (da_data !== 8'(fixed)) begin
                    errors++;
                    $display("FAIL flip_latency: da_data=%0d expected %0d (edge %0d)", da_data, fixed, i + 1);
                end
            end
        end
    endtask

    task automatic test_patterns();
        logic bits [$];
        logic b;
        int   e;
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 20; i++) bits.push_back(1'b1);
            for (int i = 0; i < 40; i++) bits.push_back(1'b0);
        end
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < 10; i++) bits.push_back(1'b1);
            for (int i = 0; i < 10; i++) bits.push_back(1'b0);
        end
        for (int r = 0; r < 20; r++) begin
            b = 1'($urandom_range(0, 1));
            for (int i = 0; i < 40; i++) bits.push_back(b);
        end
        foreach (bits[i]) begin
            step(1'b0, bits[i], e);
            checks++;
            if (da_data !== 8'(e)) begin
                errors++;
                $display("FAIL pattern: da_data=%0d expected %0d (bit index %0d)", da_data, e, i);
            end
        end
    endtask

    task automatic test_wrap();
        int e;
        int prev;
        int dlt;
        step(1'b1, 1'b0, e);
        prev = e;
        for (int i = 0; i < 200; i++) begin
            step(1'b0, 1'b0, e);
            checks++;
            if (da_data !== 8'(e)) begin
                errors++;
                $display("FAIL wrap_model: da_data=%0d expected %0d (edge %0d)", da_data, e, i + 1);
            end
            dlt = int'(da_data) - prev;
            checks++;
            if (dlt < -10 || dlt > 10) begin
                errors++;
                $display("FAIL wrap_continuity: da_data=%0d previous expected %0d (edge %0d)", da_data, prev, i + 1);
            end
            prev = e;
        end
    endtask

    task automatic test_mid_reset();
        int e;
        int n;
        int fixed [3];
        fixed[0] = 128;
        fixed[1] = 128;
        fixed[2] = 121;
        n = $urandom_range(30, 70);
        for (int i = 0; i < n; i++) begin
            step(1'b0, 1'b1, e);
            checks++;
            if (da_data !== 8'(e)) begin
                errors++;
                $display("FAIL midrst_pre: da_data=%0d expected %0d (edge %0d)", da_data, e, i + 1);
            end
        end
        for (int i = 0; i < 3; i++) begin
            step((i == 0) ? 1'b1 : 1'b0, 1'b1, e);
            checks++;
            if (da_data !== 8'(fixed[i])) begin
                errors++;
                $display("FAIL midrst_key: da_data=%0d expected %0d (step %0d)", da_data, fixed[i], i);
            end
        end
        for (int i = 0; i < 40; i++) begin
            step(1'b0, 1'($urandom_range(0, 1)), e);
            checks++;
            if (da_data !== 8'(e)) begin
                errors++;
                $display("FAIL midrst_resume: da_data=%0d expected %0d (edge %0d)", da_data, e, i + 1);
            end
        end
    endtask

    initial begin
        for (int k = 0; k < 256; k++) lut[k] = ref_sample(k);
        test_reset();
        test_release();
        test_phase_flip();
        test_patterns();
        test_wrap();
        test_mid_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
